spiflash_read_arbiter: RTL and testbench

//  Shares the single SPI NOR flash (READ 0x03, mode 0) between two byte-read requesters:

---
 rtl/spiflash_pkg.sv | 19 +
 rtl/spiflash_read_arbiter_shifter.sv | 71 +++++++
 rtl/spiflash_read_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spiflash_read_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_pkg.sv
// Shared constants and FSM state type for the SPI NOR flash read arbiter.
// Imported by spi_byte_shifter and spiflash_read_arbiter.
package spiflash_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         FLASH_ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        DESEL,
        CMD,
        A2,
        A1,
        A0,
        DATA,
        DONE
    } arb_state_t;

endpackage

// File: rtl/spiflash_read_arbiter_shifter.sv
// SPI mode-0 byte engine: MSB-first MOSI shift, MISO capture on SCLK rise,
// SCK_HALF clock divider and a done strobe in the last clk of the byte.
module spi_byte_shifter
    import spiflash_pkg::*;
#(
    parameter int SCK_HALF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_done,
    output logic [7:0] o_rx
);

    localparam int            DW       = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_HALF - 1);

    logic          r_busy;
    logic [DW-1:0] r_div;
    logic [3:0]    r_half;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_sck;
    logic          w_div_end;

    assign w_div_end = (r_div == DIV_LAST);
    assign o_done    = r_busy && w_div_end && (r_half == 4'd15);
    assign o_sck     = r_sck;
    assign o_mosi    = r_tx[7];
    assign o_rx      = r_rx;

    // Even half-periods are SCLK low, odd ones high; 16 halves per byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= '0;
            r_half <= 4'd0;
            r_tx   <= 8'h00;
            r_rx   <= 8'h00;
            r_sck  <= 1'b0;
        end else if (i_load) begin
            r_busy <= 1'b1;
            r_div  <= '0;
            r_half <= 4'd0;
            r_tx   <= i_byte;
            r_sck  <= 1'b0;
        end else if (r_busy) begin
            if (w_div_end) begin
                r_div  <= '0;
                r_half <= r_half + 4'd1;
                if (!r_half[0]) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], i_miso};
                end else begin
                    r_sck <= 1'b0;
                    r_tx  <= {r_tx[6:0], 1'b0};
                end
                if (r_half == 4'd15) begin
                    r_busy <= 1'b0;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/spiflash_read_arbiter.sv
// Two-port byte-read arbiter for a SPI NOR flash; keeps CS low across sequential reads.
// Define SPIFLASH_ARB_RR_EN for round-robin arbitration (fixed priority to port 0 otherwise).
module spiflash_read_arbiter
    import spiflash_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int            GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_owner;
    logic              r_cont_valid;
    logic              r_cs_n;
    logic              r_ack0;
    logic              r_ack1;
    logic [7:0]        r_rdata;
    logic [GW-1:0]     r_gap;
`ifdef SPIFLASH_ARB_RR_EN
    logic              r_rr_last;
`endif

    logic                    w_any;
    logic                    w_pick1;
    logic                    w_hit;
    logic                    w_load;
    logic [7:0]              w_byte;
    logic [ADDR_W-1:0]       w_win_addr;
    logic [ADDR_W:0]         w_seq_addr;
    logic [FLASH_ADDR_W-1:0] w_faddr;
    logic                    w_done;
    logic [7:0]              w_rx;

    assign w_any = req0 | req1;
`ifdef SPIFLASH_ARB_RR_EN
    assign w_pick1 = req1 & (~req0 | ~r_rr_last);
`else
    assign w_pick1 = req1 & ~req0;
`endif
    assign w_win_addr = w_pick1 ? addr1 : addr0;

    // One extra bit so the top address never "continues" into address 0.
    assign w_seq_addr = {1'b0, r_last_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_hit      = r_cont_valid && !r_cs_n &&
                        ({1'b0, w_win_addr} == w_seq_addr);
    assign w_faddr    = FLASH_ADDR_W'(r_cur_addr);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_byte = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = w_hit ? DATA : DESEL;
                    w_load = w_hit;
                end
            end
            DESEL: begin
                if (r_gap == GAP_LAST) begin
                    w_next = CMD;
                    w_load = 1'b1;
                    w_byte = SPI_CMD_READ;
                end
            end
            CMD: begin
                if (w_done) begin
                    w_next = A2;
                    w_load = 1'b1;
                    w_byte = w_faddr[23:16];
                end
            end
            A2: begin
                if (w_done) begin
                    w_next = A1;
                    w_load = 1'b1;
                    w_byte = w_faddr[15:8];
                end
            end
            A1: begin
                if (w_done) begin
                    w_next = A0;
                    w_load = 1'b1;
                    w_byte = w_faddr[7:0];
                end
            end
            A0: begin
                if (w_done) begin
                    w_next = DATA;
                    w_load = 1'b1;
                end
            end
            DATA: begin
                if (w_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_last_addr  <= '0;
            r_owner      <= 1'b0;
            r_cont_valid <= 1'b0;
            r_cs_n       <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata      <= 8'h00;
            r_gap        <= '0;
`ifdef SPIFLASH_ARB_RR_EN
            r_rr_last    <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_cur_addr <= w_win_addr;
                r_owner    <= w_pick1;
                r_gap      <= '0;
                if (!w_hit) begin
                    r_cs_n <= 1'b1;
                end
`ifdef SPIFLASH_ARB_RR_EN
                r_rr_last <= w_pick1;
`endif
            end
            if (r_state == DESEL) begin
                r_gap <= r_gap + GW'(1);
                if (w_next == CMD) begin
                    r_cs_n <= 1'b0;
                end
            end
            // Ack and data land together in the DONE cycle.
            if (r_state == DATA && w_done) begin
                r_rdata      <= w_rx;
                r_ack0       <= ~r_owner;
                r_ack1       <= r_owner;
                r_last_addr  <= r_cur_addr;
                r_cont_valid <= 1'b1;
            end
        end
    end

    spi_byte_shifter #(
        .SCK_HALF (SCK_HALF)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_byte (w_byte),
        .i_miso (spi_miso),
        .o_sck  (spi_sck),
        .o_mosi (spi_mosi),
        .o_done (w_done),
        .o_rx   (w_rx)
    );

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata    = r_rdata;
    assign busy     = (r_state != IDLE);
    assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spiflash_read_arbiter.sv
// Randomised bench with a flash pin model and a transaction-level timing model.
// Covers hit/miss latency, wrap miss, arbitration, mid-transaction reset and streaming.
module tb_spiflash_read_arbiter;

    localparam int AW     = 12;
    localparam int SH     = 2;
    localparam int GAP    = 1;
    localparam int L_HIT  = 16 * SH + 2;
    localparam int L_MISS = GAP + 80 * SH + 2;
    localparam int INF    = 32'h7fff_ffff;
`ifdef SPIFLASH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic          ack0;
    logic          ack1;
    logic [7:0]    rdata;
    logic          busy;
    logic          spi_cs_n;
    logic          spi_sck;
    logic          spi_mosi;
    logic          spi_miso = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int cs_falls = 0;
    int cs_rises = 0;

    spiflash_read_arbiter #(
        .ADDR_W   (AW),
        .SCK_HALF (SH),
        .CS_GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rdata    (rdata),
        .busy     (busy),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge spi_cs_n) cs_falls++;
    always @(posedge spi_cs_n) cs_rises++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Flash: decodes 03+addr on SCLK rise, streams bytes MSB first on SCLK fall.
    logic [7:0]  mem [0:4095];
    logic [31:0] f_sh = '0;
    int          f_bits = 0;
    logic [23:0] f_addr = '0;
    logic [7:0]  f_out = '0;
    int          exp_cmd_addr = 0;

    always @(posedge spi_cs_n) f_bits = 0;

    always @(posedge spi_sck) begin
        if (spi_cs_n === 1'b0) begin
            f_sh = {f_sh[30:0], spi_mosi};
            f_bits++;
            if (f_bits == 32) begin
                f_addr = f_sh[23:0];
                chk("flash_cmd", f_sh[31:24], 8'h03);
                chk("flash_addr", f_sh[23:0], exp_cmd_addr);
            end
        end
    end

    always @(negedge spi_sck) begin
        int k;
        if (spi_cs_n === 1'b0 && f_bits >= 32) begin
            k = (f_bits - 32) % 8;
            if (k == 0) begin
                f_out = mem[f_addr[11:0]];
                f_addr++;
            end
            spi_miso = f_out[7-k];
        end
    end

    // Transaction model: grant in an idle cycle fixes the ack cycle from the latency rule.
    int         m_free = 0;
    int         m_ack_cyc = -1;
    int         m_cs_lo = INF;
    int         m_last = 0;
    int         m_addr = 0;
    bit         m_port = 1'b0;
    bit         m_cont = 1'b0;
    bit         m_rr = 1'b1;
    logic [7:0] m_rdata = 8'h00;
    bit         prev_sck_hi = 1'b0;
    logic       prev_mosi = 1'b0;

    always @(negedge clk) begin
        bit p1;
        bit hit;
        int a;
        int lat;
        if (cyc >= 1) begin
            if (cyc == m_ack_cyc) begin
                m_rdata = mem[m_addr];
                m_last  = m_addr;
                m_cont  = 1'b1;
            end
            chk("ack0", ack0, (cyc == m_ack_cyc) && !m_port);
            chk("ack1", ack1, (cyc == m_ack_cyc) && m_port);
            chk("busy", busy, cyc < m_free);
            chk("rdata", rdata, m_rdata);
            chk("cs_n", spi_cs_n, cyc < m_cs_lo);
            if (cyc >= m_free) chk("sck_idle", spi_sck, 1'b0);
            if (spi_sck === 1'b1 && prev_sck_hi) chk("mosi_stable", spi_mosi, prev_mosi);
            prev_sck_hi = (spi_sck === 1'b1);
            prev_mosi   = spi_mosi;
            if (!rst_n) begin
                m_free    = cyc + 1;
                m_ack_cyc = -1;
                m_cs_lo   = INF;
                m_cont    = 1'b0;
                m_rr      = 1'b1;
                m_rdata   = 8'h00;
            end else if (cyc >= m_free && (req0 || req1)) begin
                p1  = req1 && (!req0 || (RR && !m_rr));
                a   = p1 ? int'(addr1) : int'(addr0);
                hit = m_cont && (a == m_last + 1);
                lat = hit ? L_HIT : L_MISS;
                m_port    = p1;
                m_addr    = a;
                m_ack_cyc = cyc + lat - 1;
                m_free    = cyc + lat;
                if (!hit) begin
                    m_cs_lo      = cyc + GAP + 1;
                    exp_cmd_addr = a;
                end
                if (RR) m_rr = p1;
            end
        end
    end

    // Called just after a posedge; returns inclusive grant-to-ack cycle counts.
    task automatic run(input bit u0, input int a0, input bit u1, input int a1,
                       output int l0, output int l1);
        int t0;
        bit d0;
        bit d1;
        l0 = -1;
        l1 = -1;
        d0 = !u0;
        d1 = !u1;
        if (u0) begin req0 = 1'b1; addr0 = AW'(a0); end
        if (u1) begin req1 = 1'b1; addr1 = AW'(a1); end
        t0 = cyc;
        for (int i = 0; i < 1000 && !(d0 && d1); i++) begin
            @(negedge clk);
            if (!d0 && ack0 === 1'b1) begin d0 = 1'b1; l0 = cyc - t0 + 1; end
            if (!d1 && ack1 === 1'b1) begin d1 = 1'b1; l1 = cyc - t0 + 1; end
            @(posedge clk); #1;
            if (d0 && u0) req0 = 1'b0;
            if (d1 && u1) req1 = 1'b0;
        end
        chk("ack_seen", {30'd0, d0, d1}, 32'd3);
    endtask

    initial begin
        int l0;
        int l1;
        int c0;
        int a;
        int b;
        int mode;
        bit seen;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[4]    = 8'h5A;
        mem[5]    = 8'hC3;
        mem[0]    = 8'h81;
        mem[4095] = 8'h7E;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_sck", spi_sck, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_acks", {ack0, ack1}, 2'b00);
        @(posedge clk); #1;

        c0 = cs_falls;
        run(1, 12'h004, 0, 0, l0, l1);
        chk("t1_lat", l0, 163);
        chk("t1_rdata", rdata, 8'h5A);
        chk("t1_cs_fall", cs_falls - c0, 1);

        c0 = cs_falls + cs_rises;
        run(1, 12'h005, 0, 0, l0, l1);
        chk("t2_lat", l0, 34);
        chk("t2_rdata", rdata, 8'hC3);
        chk("t2_cs_quiet", cs_falls + cs_rises - c0, 0);

        run(1, 12'hFFF, 0, 0, l0, l1);
        chk("t3a_rdata", rdata, 8'h7E);
        c0 = cs_rises;
        run(1, 12'h000, 0, 0, l0, l1);
        chk("t3_lat", l0, 163);
        chk("t3_rdata", rdata, 8'h81);
        chk("t3_cs_pulse", cs_rises - c0, 1);

        for (int p = 0; p < 4; p++) begin
            run(1, 12'h200 + p, 1, 12'h300 + p, l0, l1);
            chk("t4_order_p0_first", l0 < l1, !RR);
        end

        run(1, 12'h020, 0, 0, l0, l1);
        req0 = 1'b1;
        addr0 = 12'h040;
        repeat (70) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_cs_n", spi_cs_n, 1'b1);
        chk("t5_sck", spi_sck, 1'b0);
        chk("t5_busy", busy, 1'b0);
        @(posedge clk); #1;
        run(1, 12'h021, 0, 0, l0, l1);
        chk("t5_miss_lat", l0, 163);

        run(0, 0, 1, 12'h100, l0, l1);
        chk("t6_lat0", l1, 163);
        run(0, 0, 1, 12'h101, l0, l1);
        chk("t6_lat1", l1, 34);
        run(0, 0, 1, 12'h102, l0, l1);
        chk("t6_lat2", l1, 34);
        chk("t6_rdata", rdata, mem[12'h102]);

        req1 = 1'b1;
        addr1 = 12'h777;
        repeat (3) @(posedge clk);
        #1 req1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) seen = 1'b1;
        end
        chk("drop_ack", seen, 1'b1);
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            a = ($urandom_range(0, 9) < 5) ? ((m_last + 1) & 12'hFFF) : $urandom_range(0, 4095);
            if ($urandom_range(0, 9) == 0) a = 12'hFFF;
            b = ($urandom_range(0, 1) == 1) ? ((a + 1) & 12'hFFF) : $urandom_range(0, 4095);
            run(mode != 1, a, mode != 0, b, l0, l1);
            if (mode != 1) chk("rnd_lat0", (l0 == L_HIT || l0 >= L_MISS), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        nerr++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog expired");
    end

endmodule
